// File: rtl/game_event_sync_if.sv
// Button, ack and event signals between the dino-game input stage and the regfile wrapper.
// The master drives the raw buttons and the ack register; the slave (game_event_sync) returns events.
interface game_event_sync_if;
  logic        jump_btn_raw;
  logic        pause_btn_raw;
  logic [31:0] ack;
  logic        button_signal;
  logic        screen_signal;
  logic        pause_signal;
  logic [31:0] frame_count;
  logic        overrun;

  modport master (
    output jump_btn_raw,
    output pause_btn_raw,
    output ack,
    input  button_signal,
    input  screen_signal,
    input  pause_signal,
    input  frame_count,
    input  overrun
  );

  modport slave (
    input  jump_btn_raw,
    input  pause_btn_raw,
    input  ack,
    output button_signal,
    output screen_signal,
    output pause_signal,
    output frame_count,
    output overrun
  );
endinterface

// File: rtl/game_event_sync.sv
// Synchronizes/debounces the jump and pause buttons, produces sticky set/ack events and a frame tick.
// Optional macro PAUSE_FREEZE_EN: frame divider, frame_count and overrun freeze while paused.
module game_event_sync #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int FRAME_DIV       = 833333,
  parameter int FRAME_W         = 20
) (
  input  logic            clock,
  input  logic            reset,
  game_event_sync_if.slave bus
);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);

  // Index 0 is the jump button, index 1 the pause button.
  logic [1:0] raw_btn;
  logic [1:0] btn_rise;

  assign raw_btn = {bus.pause_btn_raw, bus.jump_btn_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            s1_q, s1_d;
      logic            s2_q, s2_d;
      logic            st_q, st_d;
      logic            st_prev_q, st_prev_d;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        s1_d      = raw_btn[gi];
        s2_d      = s1_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        st_prev_d = st_q;
        if (s2_q == st_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d  = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          st_q      <= 1'b0;
          st_prev_q <= 1'b0;
          cnt_q     <= '0;
        end else begin
          s1_q      <= s1_d;
          s2_q      <= s2_d;
          st_q      <= st_d;
          st_prev_q <= st_prev_d;
          cnt_q     <= cnt_d;
        end
      end

      assign btn_rise[gi] = st_q & ~st_prev_q;
    end
  endgenerate

  logic               jump_rise;
  logic               pause_rise;
  logic [2:0]         ack_q, ack_d;
  logic [2:0]         ack_rise;
  logic [FRAME_W-1:0] div_q, div_d;
  logic               tick;
  logic               freeze;
  logic               button_signal_q, button_signal_d;
  logic               screen_signal_q, screen_signal_d;
  logic               pause_signal_q, pause_signal_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        frame_count_q, frame_count_d;
  logic               unused_ack_bits;

  assign jump_rise       = btn_rise[0];
  assign pause_rise      = btn_rise[1];
  assign unused_ack_bits = ^bus.ack[31:3];

`ifdef PAUSE_FREEZE_EN
  assign freeze = pause_signal_q;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    ack_d           = bus.ack[2:0];
    ack_rise        = bus.ack[2:0] & ~ack_q;
    tick            = (div_q == FRAME_LAST) && !freeze;
    div_d           = div_q;
    button_signal_d = button_signal_q;
    screen_signal_d = screen_signal_q;
    pause_signal_d  = pause_signal_q ^ pause_rise;
    overrun_d       = overrun_q;
    frame_count_d   = frame_count_q;

    if (!freeze) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    // Clear first, then set, so a set arriving with its ack wins.
    if (ack_rise[0]) button_signal_d = 1'b0;
    if (jump_rise)   button_signal_d = 1'b1;

    if (ack_rise[1]) screen_signal_d = 1'b0;
    if (tick)        screen_signal_d = 1'b1;

    if (!freeze) begin
      if (ack_rise[2]) overrun_d = 1'b0;
      if (tick && screen_signal_q && !ack_rise[1]) overrun_d = 1'b1;
    end

    if (tick) frame_count_d = frame_count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q           <= '0;
      div_q           <= '0;
      button_signal_q <= 1'b0;
      screen_signal_q <= 1'b0;
      pause_signal_q  <= 1'b0;
      overrun_q       <= 1'b0;
      frame_count_q   <= '0;
    end else begin
      ack_q           <= ack_d;
      div_q           <= div_d;
      button_signal_q <= button_signal_d;
      screen_signal_q <= screen_signal_d;
      pause_signal_q  <= pause_signal_d;
      overrun_q       <= overrun_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign bus.button_signal = button_signal_q;
  assign bus.screen_signal = screen_signal_q;
  assign bus.pause_signal  = pause_signal_q;
  assign bus.overrun       = overrun_q;
  assign bus.frame_count   = frame_count_q;

endmodule

// File: tb/tb_game_event_sync.sv
// Directed bench for game_event_sync with DEBOUNCE_CYCLES=4 and FRAME_DIV=10.
// Edge numbers in comments count rising edges after reset is released.
module tb_game_event_sync;
  logic clock;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  game_event_sync_if bus_if ();

  game_event_sync #(
    .DEBOUNCE_CYCLES (4),
    .DB_W            (3),
    .FRAME_DIV       (10),
    .FRAME_W         (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef PAUSE_FREEZE_EN
  localparam logic [31:0] FC_PAUSED  = 32'd0;
  localparam logic [31:0] FC_RESUMED = 32'd1;
`else
  localparam logic [31:0] FC_PAUSED  = 32'd1;
  localparam logic [31:0] FC_RESUMED = 32'd3;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset                = 1'b1;
    bus_if.jump_btn_raw  = 1'b0;
    bus_if.pause_btn_raw = 1'b0;
    bus_if.ack           = 32'd0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_button"}, 32'(bus_if.button_signal), 32'd0);
    check_val({tag, "_screen"}, 32'(bus_if.screen_signal), 32'd0);
    check_val({tag, "_pause"},  32'(bus_if.pause_signal),  32'd0);
    check_val({tag, "_overrun"}, 32'(bus_if.overrun),      32'd0);
    check_val({tag, "_fcount"}, bus_if.frame_count,        32'd0);
  endtask

  initial begin
    logic seen;
    vec_cnt = 0;
    err_cnt = 0;

    // 1: idle frame ticks and overrun
    do_reset();
    check_all_zero("rst");
    step(9);
    check_val("t1_screen_e9", 32'(bus_if.screen_signal), 32'd0);
    step(1);
    check_val("t1_screen_e10", 32'(bus_if.screen_signal), 32'd1);
    check_val("t1_fcount_e10", bus_if.frame_count, 32'd1);
    step(9);
    check_val("t1_overrun_e19", 32'(bus_if.overrun), 32'd0);
    step(1);
    check_val("t1_overrun_e20", 32'(bus_if.overrun), 32'd1);
    check_val("t1_fcount_e20", bus_if.frame_count, 32'd2);
    step(5);
    check_val("t1_button", 32'(bus_if.button_signal), 32'd0);
    check_val("t1_pause", 32'(bus_if.pause_signal), 32'd0);
    bus_if.ack = 32'h4;
    step(1);
    check_val("t1_overrun_ack", 32'(bus_if.overrun), 32'd0);
    bus_if.ack = 32'd0;

    // 2: jump latency, ack clears, held ack does not mask the next press
    do_reset();
    bus_if.jump_btn_raw = 1'b1;
    step(6);
    check_val("t2_button_e5", 32'(bus_if.button_signal), 32'd0);
    step(1);
    check_val("t2_button_e6", 32'(bus_if.button_signal), 32'd1);
    bus_if.ack = 32'h1;
    step(1);
    check_val("t2_button_ack", 32'(bus_if.button_signal), 32'd0);
    bus_if.jump_btn_raw = 1'b0;
    step(10);
    check_val("t2_button_released", 32'(bus_if.button_signal), 32'd0);
    bus_if.jump_btn_raw = 1'b1;
    step(6);
    check_val("t2_button_re_e5", 32'(bus_if.button_signal), 32'd0);
    step(1);
    check_val("t2_button_re_e6", 32'(bus_if.button_signal), 32'd1);
    bus_if.ack = 32'd0;
    bus_if.jump_btn_raw = 1'b0;

    // 3: three-cycle glitch is rejected
    do_reset();
    bus_if.jump_btn_raw = 1'b1;
    step(3);
    bus_if.jump_btn_raw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen = seen | bus_if.button_signal;
    end
    check_val("t3_glitch", 32'(seen), 32'd0);

    // 4: frame ack just before a tick, and ack colliding with a tick
    do_reset();
    step(10);
    check_val("t4_screen_e10", 32'(bus_if.screen_signal), 32'd1);
    step(8);
    bus_if.ack = 32'h2;
    step(1);
    check_val("t4_screen_ack_e19", 32'(bus_if.screen_signal), 32'd0);
    bus_if.ack = 32'd0;
    step(1);
    check_val("t4_screen_e20", 32'(bus_if.screen_signal), 32'd1);
    check_val("t4_overrun_e20", 32'(bus_if.overrun), 32'd0);
    step(9);
    bus_if.ack = 32'h2;
    step(1);
    check_val("t4_screen_collide", 32'(bus_if.screen_signal), 32'd1);
    check_val("t4_overrun_collide", 32'(bus_if.overrun), 32'd0);
    check_val("t4_fcount_e30", bus_if.frame_count, 32'd3);
    bus_if.ack = 32'd0;

    // 5: pause toggles on presses only
    do_reset();
    bus_if.pause_btn_raw = 1'b1;
    step(8);
    check_val("t5_pause_on", 32'(bus_if.pause_signal), 32'd1);
    check_val("t5_fcount_e8", bus_if.frame_count, 32'd0);
    bus_if.pause_btn_raw = 1'b0;
    step(8);
    check_val("t5_pause_release", 32'(bus_if.pause_signal), 32'd1);
    check_val("t5_fcount_e16", bus_if.frame_count, FC_PAUSED);
    bus_if.pause_btn_raw = 1'b1;
    step(8);
    check_val("t5_pause_off", 32'(bus_if.pause_signal), 32'd0);
    bus_if.pause_btn_raw = 1'b0;
    step(6);
    check_val("t5_fcount_e30", bus_if.frame_count, FC_RESUMED);
    check_val("t5_pause_final", 32'(bus_if.pause_signal), 32'd0);

    // 6: mid-operation reset discards everything
    do_reset();
    bus_if.jump_btn_raw = 1'b1;
    step(7);
    check_val("t6_button_pre", 32'(bus_if.button_signal), 32'd1);
    step(68);
    check_val("t6_overrun_pre", 32'(bus_if.overrun), 32'd1);
    check_val("t6_fcount_pre", bus_if.frame_count, 32'd7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    bus_if.jump_btn_raw = 1'b0;
    check_all_zero("t6_rst");
    step(9);
    check_val("t6_screen_e9", 32'(bus_if.screen_signal), 32'd0);
    step(1);
    check_val("t6_screen_e10", 32'(bus_if.screen_signal), 32'd1);
    check_val("t6_button_post", 32'(bus_if.button_signal), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/game_event_sync.md
Name: game_event_sync

Overview:
- Upstream input stage for the processor/regfile wrapper in the dino game.
- Turns asynchronous board buttons and the system clock into the clean, sticky event bits the regfile exposes to software: `button_signal`, `screen_signal` and `pause_signal`.
- Software acknowledges events through bits of a processor-written register, which closes a set/ack handshake.
- Also supplies a running frame counter for a spare input register.

Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); must be >= 2.
- `DB_W`, 20: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `FRAME_DIV`, 833333: clock cycles per frame tick (60 Hz at 50 MHz); must be >= 2.
- `FRAME_W`, 20: frame divider width; must hold `FRAME_DIV-1`.

Ports:
- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `jump_btn_raw` in 1: asynchronous jump button, active-high.
- `pause_btn_raw` in 1: asynchronous pause button, active-high.
- `ack` in 32: processor-written register value. Bit 0 acks the button, bit 1 acks the frame, bit 2 clears overrun. Bits 31:3 are ignored.
- `button_signal` out 1: sticky jump event.
- `screen_signal` out 1: sticky frame tick.
- `pause_signal` out 1: pause toggle state.
- `frame_count` out 32: number of frame ticks since reset.
- `overrun` out 1: sticky flag; a frame tick arrived while `screen_signal` was still set.

Behaviour:
- Reset (synchronous, priority over everything):
  - All outputs are 0.
  - Synchronizers, stable levels, debounce counters, frame divider and `ack_q` are all 0.
- Synchronizer: each raw button passes through a 2-flop synchronizer (`s1` then `s2`).
- Debounce, per button:
  - Keeps a stable level `st` and a counter `cnt`.
  - If `s2 == st`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `st` <= `s2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `st`.
- Event pulses: `jump_rise = st_jump & ~st_jump_q`; `pause_rise` is formed the same way. Each is a one-cycle pulse.
- Latency: with the raw input held high from sampling edge 0, `st` flips at edge `DEBOUNCE_CYCLES+1` and `button_signal` rises at edge `DEBOUNCE_CYCLES+2`.
- Ack detection:
  - `ack_q[2:0]` registers `ack[2:0]`; `ack_rise = ack[2:0] & ~ack_q`.
  - Only rising edges act, so holding an ack bit at 1 does not mask later events.
  - An ack bit that is already 1 on the first cycle after reset counts as a rise.
- `button_signal`: set on `jump_rise`; cleared on `ack_rise[0]`. Set wins if both occur in the same cycle. Additional presses while set are merged.
- Frame divider:
  - Counts 0..`FRAME_DIV-1`. On wrap it returns to 0 and generates `tick`.
  - The first tick occurs at the `FRAME_DIV`-th edge after reset deasserts; period thereafter is exactly `FRAME_DIV`.
- `screen_signal`: set on `tick`; cleared on `ack_rise[1]`. Set wins on collision.
- `overrun`:
  - Set when `tick` occurs while `screen_signal` is 1 and `ack_rise[1]` is 0 in that cycle.
  - Cleared only by `ack_rise[2]` or reset; set wins on collision.
- `frame_count`: increments by 1 on each `tick`; wraps from `0xFFFFFFFF` to 0.
- `pause_signal`: toggles on each `pause_rise`. Releasing the button has no effect.
- Mid-operation reset: any in-progress debounce count or pending event is discarded; outputs are 0 on the next cycle.

Optional Feature:
- Macro: `PAUSE_FREEZE_EN`.
- Defined: while `pause_signal == 1`:
  - The frame divider holds its value, no ticks occur, and `frame_count` and `overrun` are frozen.
  - `screen_signal` keeps its state and can still be acked.
  - Counting resumes from the held divider value on the cycle after `pause_signal` returns to 0.
- Not defined: the divider and `frame_count` run regardless of `pause_signal`.

Test Plan (`DEBOUNCE_CYCLES=4`, `FRAME_DIV=10`):
1. Reset, then 25 idle cycles -> `screen_signal` rises at edge 10, `frame_count=1`. At edge 20, `overrun=1` and `frame_count=2`. `button_signal` and `pause_signal` stay 0.
2. `jump_btn_raw`=1 held from edge 0 -> `button_signal`=1 at edge 6. Raise `ack[0]` -> cleared next edge. Hold `ack[0]`=1 and press again -> `button_signal` sets again.
3. `jump_btn_raw` pulse of 3 cycles, then 0 -> `button_signal` never asserts.
4. `screen_signal`=1; pulse `ack[1]` one cycle before the next tick -> `overrun` stays 0. Also drive `ack[1]` rise and tick in the same cycle -> `screen_signal` stays 1 and `overrun` stays 0.
5. Two clean pause presses -> `pause_signal` goes 0→1→0. With `PAUSE_FREEZE_EN`, `frame_count` is constant while paused; without it, `frame_count` keeps incrementing.
6. Assert `reset` for one cycle with `button_signal=1`, `overrun=1` and `frame_count=7` -> all outputs 0 next cycle; next `screen_signal` arrives 10 edges after reset deasserts.
